scan_ctrl_4dig: RTL
===================

# scan_ctrl_4dig

Four-digit multiplex scanner that drives the select and enable inputs of the 2-to-4 active-low digit decoder (G_L, A, B) and presents the matching 4-bit digit value to the downstream segment encoder. It sits directly upstream of the decoder in the display path. It time-slices a 16-bit display word across four digit slots, inserts a blanking gap at each slot start to suppress ghosting, and double-buffers the word so updates apply only at frame boundaries.

## Interface
- DIV, 50000: clock cycles per digit slot; legal range DIV ≥ 2
- BLANK, 16: blanked cycles at the start of each slot; legal range 1 ≤ BLANK < DIV
- CLK  in  1  single clock; all state changes on rising edge
- RESET  in  1  asynchronous, active-high reset
- EN  in  1  scanning enable
- LD  in  1  one-cycle load strobe for DATA
- DATA  in  16  display word; digit n = DATA[4n+3:4n]
- PENDING  out  1  shadow word is waiting for commit
- G_L  out  1  decoder enable, active-low
- A  out  1  digit select LSB
- B  out  1  digit select MSB
- NIBBLE  out  4  value of the currently selected digit
- FRAME  out  1  one-cycle pulse on each commit / frame boundary

## Operation
- Reset values, all asynchronous:
  - pcnt = 0, digit = 0, shadow = 0, active = 0
  - PENDING = 0, G_L = 1, A = B = 0, NIBBLE = 0, FRAME = 0
- State machine:
  - OFF: EN = 0.
  - BLANK: EN = 1 and pcnt < BLANK.
  - SHOW: EN = 1 and pcnt ≥ BLANK.
  - G_L = 0 only in SHOW.
- pcnt:
  - Counts 0..DIV-1 while EN = 1.
  - At pcnt = DIV-1 it wraps to 0 and digit increments modulo 4 (3 → 0).
- {B, A} = digit. NIBBLE = active[4·digit+3 : 4·digit].
  - All four are registered and updated on the same edge as G_L.
- Load:
  - LD = 1 captures shadow ← DATA and sets PENDING = 1.
  - A later LD before commit overwrites shadow (last write wins).
- Commit happens when either:
  - digit wraps 3 → 0, or
  - OFF and PENDING = 1, on the next edge.
- At commit: active ← shadow, PENDING ← 0, FRAME pulses for 1 cycle. FRAME does not pulse if nothing is pending.
- LD in the same cycle as a commit:
  - active ← DATA directly.
  - shadow ← DATA.
  - PENDING ends at 0.
- EN falling in any state:
  - Next edge: OFF, G_L = 1, pcnt = 0, digit = 0.
  - active is retained.
- EN rising: scanning starts at digit 0, pcnt 0 (BLANK).
- RESET mid-scan: all state is forced to reset values immediately. Scanning resumes from digit 0 after RESET releases if EN = 1.

## Timing
- Slot length is DIV cycles: BLANK cycles with G_L = 1, then DIV-BLANK cycles with G_L = 0. Frame length is 4·DIV cycles.
- Digit change and NIBBLE change occur on the same edge. G_L is already 1 on that edge, so no mixed digit/value pair is ever enabled.
- LD → PENDING = 1: 1 cycle.
- Commit → new NIBBLE at digit 0: same edge as the 3 → 0 wrap.
- EN sampled high at edge k → first G_L = 0 at edge k+BLANK.
- EN sampled low → G_L = 1 at the next edge.

## Structure
- Shared package `scan_pkg`:
  - state encoding: OFF, BLANK, SHOW
  - digit width constant (2)
  - digit count constant (4)
  - nibble width constant (4)
- Sub-module `tick_gen`:
  - parameterised modulo-DIV prescaler with clear input
  - outputs count and wrap pulse
- Top level holds digit counter, shadow/active registers, commit logic and output registers.

## Test plan
All scenarios use DIV = 8, BLANK = 2.
- Reset then EN = 1, no LD:
  - G_L = 1 for 2 cycles, then 0 for 6.
  - {B, A} steps 0, 1, 2, 3, 0 every 8 cycles.
  - NIBBLE = 0 throughout.
  - FRAME never pulses.
- LD with DATA = 0x4321 mid digit 1:
  - PENDING = 1 next cycle.
  - NIBBLE unchanged until the 3 → 0 wrap.
  - At the wrap: FRAME = 1 for one cycle, PENDING = 0.
  - NIBBLE sequence in SHOW: 1, 2, 3, 4.
- Two LDs (0x1111, then 0x2222) in one frame:
  - After the wrap, NIBBLE = 2 in every slot.
- LD 0xABCD on the exact cycle digit wraps 3 → 0:
  - NIBBLE = D at digit 0 immediately.
  - PENDING stays 0.
  - FRAME = 1.
- EN dropped mid SHOW at digit 2:
  - Next edge: G_L = 1, {B, A} = 0.
  - EN reasserted: 2 blank cycles, then digit 0 shown.
- RESET pulse mid-frame with a pending word:
  - All outputs go to reset values immediately.
  - The pending word is lost.
  - Scanning restarts at digit 0.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the four-digit multiplex scanner: state encoding,
// digit/nibble geometry and the nibble-select helper.
package scan_pkg;

   localparam int DIGIT_W    = 2;
   localparam int NUM_DIGITS = 4;
   localparam int NIBBLE_W   = 4;
   localparam int WORD_W     = NUM_DIGITS * NIBBLE_W;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } scan_state_e;

   function automatic logic [NIBBLE_W-1:0] pick_nibble(
      input logic [WORD_W-1:0]  word,
      input logic [DIGIT_W-1:0] sel
   );
      return word[sel*NIBBLE_W +: NIBBLE_W];
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Modulo-DIV prescaler with synchronous clear; wrap is high on the cycle
// the count rolls over from DIV-1 back to 0.
module tick_gen #(
   parameter int DIV = 50000,
   parameter int CW  = $clog2(DIV)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          clr,
   output logic [CW-1:0] count,
   output logic          wrap
);

   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   assign wrap = en && !clr && (count == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= wrap ? '0 : count + 1'b1;
   end

endmodule

// File: rtl/scan_ctrl_4dig.sv
// Four-digit display scanner: blanks at each slot start, drives the active-low
// digit decoder and double-buffers the display word across frame boundaries.
module scan_ctrl_4dig
   import scan_pkg::*;
#(
   parameter int DIV   = 50000,
   parameter int BLANK = 16
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                EN,
   input  logic                LD,
   input  logic [WORD_W-1:0]   DATA,
   output logic                PENDING,
   output logic                G_L,
   output logic                A,
   output logic                B,
   output logic [NIBBLE_W-1:0] NIBBLE,
   output logic                FRAME
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0]      BLANK_C = CW'(BLANK);
   localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

   scan_state_e         state_q, state_nxt;
   logic [CW-1:0]       pcnt, pcnt_nxt;
   logic                wrap, tick_clr;
   logic [DIGIT_W-1:0]  digit_q, digit_nxt;
   logic [WORD_W-1:0]   shadow_q, active_q, active_nxt;
   logic                commit, commit_go, g_l_nxt;

   // The prescaler holds at 0 on the OFF->BLANK edge so the first slot gets
   // its full blanking gap.
   assign tick_clr = !EN || (state_q == ST_OFF);
   assign pcnt_nxt = (tick_clr || wrap) ? '0 : pcnt + 1'b1;

   tick_gen #(.DIV(DIV), .CW(CW)) u_tick (
      .clk   (CLK),
      .rst   (RESET),
      .en    (EN),
      .clr   (tick_clr),
      .count (pcnt),
      .wrap  (wrap)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= ST_OFF;
      else       state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = ST_OFF;
      if (EN) begin
         if (state_q == ST_OFF)        state_nxt = ST_BLANK;
         else if (pcnt_nxt >= BLANK_C) state_nxt = ST_SHOW;
         else                          state_nxt = ST_BLANK;
      end
   end

   always_comb begin
      g_l_nxt = (state_nxt != ST_SHOW);
   end

   assign digit_nxt = (state_nxt == ST_OFF) ? '0 :
                      (wrap ? digit_q + 1'b1 : digit_q);

   // A commit with nothing pending and no same-cycle load is a no-op.
   assign commit     = (wrap && (digit_q == LAST_DIGIT)) ||
                       ((state_q == ST_OFF) && PENDING);
   assign commit_go  = commit && (PENDING || LD);
   assign active_nxt = !commit_go ? active_q : (LD ? DATA : shadow_q);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         digit_q  <= '0;
         shadow_q <= '0;
         active_q <= '0;
         PENDING  <= 1'b0;
         G_L      <= 1'b1;
         A        <= 1'b0;
         B        <= 1'b0;
         NIBBLE   <= '0;
         FRAME    <= 1'b0;
      end else begin
         digit_q  <= digit_nxt;
         active_q <= active_nxt;
         if (LD)
            shadow_q <= DATA;
         if (commit_go)
            PENDING <= 1'b0;
         else if (LD)
            PENDING <= 1'b1;
         // Select and value move together while G_L is already high.
         G_L      <= g_l_nxt;
         {B, A}   <= digit_nxt;
         NIBBLE   <= pick_nibble(active_nxt, digit_nxt);
         FRAME    <= commit_go;
      end
   end

endmodule
